// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the single-cycle core (default
// owner, zero added latency when uncontended) and a second master (DMA/debug
// loader). DMA is protected against starvation by a wait counter and may lock
// the port for bursts of up to MAX_BURST beats.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_*  (in)           core data-memory request: W_en/R_en/addr/RW_type/wdata
//   cpu_rdata, cpu_stall  load data to core (combinational), core hold request
//   dma_*  (in)           DMA request: req/we/addr/RW_type/wdata/lock
//   dma_gnt               DMA access issued this cycle (combinational)
//   dma_rdata, dma_rvalid registered DMA read data, valid one cycle after grant
//   mem_*  (out)          muxed request to dmem; mem_dout is its combinational read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_W_en,
    input  logic        cpu_R_en,
    input  logic [31:0] cpu_addr,
    input  logic [2:0]  cpu_RW_type,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [2:0]  dma_RW_type,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,

    output logic        mem_W_en,
    output logic        mem_R_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_RW_type,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned BURST_W = 8;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_DMA_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 cpu_owed_q, cpu_owed_d;
    logic [DATA_W-1:0]    dma_rdata_q, dma_rdata_d;
    logic                 dma_rvalid_q, dma_rvalid_d;

    logic                 cpu_req;
    logic                 cpu_granted;
    logic                 dma_granted;
    logic [BURST_W-1:0]   burst_inc;

    assign cpu_req   = cpu_W_en | cpu_R_en;
    assign burst_inc = burst_cnt_q + BURST_W'(1);

    // Owner selection; nothing is granted while reset is asserted.
    always_comb begin
        cpu_granted = 1'b0;
        dma_granted = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req && dma_req) begin
                        // A forced burst exit owes the CPU the next conflict.
                        if (!cpu_owed_q && (wait_cnt_q == WAIT_W'(STARVE_LIMIT)))
                            dma_granted = 1'b1;
                        else
                            cpu_granted = 1'b1;
                    end else if (cpu_req) begin
                        cpu_granted = 1'b1;
                    end else if (dma_req) begin
                        dma_granted = 1'b1;
                    end
                end
                S_DMA_BURST: begin
                    // CPU only gets the port once DMA stops requesting.
                    if (dma_req)
                        dma_granted = 1'b1;
                    else if (cpu_req)
                        cpu_granted = 1'b1;
                end
                default: begin
                    cpu_granted = 1'b0;
                    dma_granted = 1'b0;
                end
            endcase
        end
    end

    assign dma_gnt   = dma_req & dma_granted;
    assign cpu_stall = cpu_req & ~cpu_granted;
    assign cpu_rdata = cpu_granted ? mem_dout : '0;

    // Memory-port mux; all-zero when nobody owns the port.
    always_comb begin
        mem_W_en    = 1'b0;
        mem_R_en    = 1'b0;
        mem_addr    = '0;
        mem_RW_type = '0;
        mem_din     = '0;
        if (cpu_granted) begin
            mem_W_en    = cpu_W_en;
            mem_R_en    = cpu_R_en;
            mem_addr    = cpu_addr;
            mem_RW_type = cpu_RW_type;
            mem_din     = cpu_wdata;
        end else if (dma_gnt) begin
            mem_W_en    = dma_we;
            mem_R_en    = ~dma_we;
            mem_addr    = dma_addr;
            mem_RW_type = dma_RW_type;
            mem_din     = dma_wdata;
        end
    end

    // Next-state: FSM, starvation/burst counters and DMA read capture.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cpu_owed_d   = cpu_owed_q;
        dma_rdata_d  = dma_rdata_q;
        dma_rvalid_d = 1'b0;

        if (dma_gnt)
            wait_cnt_d = '0;
        else if (dma_req && (wait_cnt_q < WAIT_W'(STARVE_LIMIT)))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);

        if (cpu_granted)
            cpu_owed_d = 1'b0;

        if (dma_gnt && !dma_we) begin
            dma_rdata_d  = mem_dout;
            dma_rvalid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (dma_gnt && dma_lock) begin
                    if (MAX_BURST <= 1) begin
                        // First beat already exhausts the burst allowance.
                        burst_cnt_d = '0;
                        cpu_owed_d  = 1'b1;
                    end else begin
                        state_d     = S_DMA_BURST;
                        burst_cnt_d = BURST_W'(1);
                    end
                end
            end
            S_DMA_BURST: begin
                if (!dma_req || !dma_lock) begin
                    state_d     = S_IDLE;
                    burst_cnt_d = '0;
                end else if (burst_inc == BURST_W'(MAX_BURST)) begin
                    // Last allowed beat is still granted, then forced out.
                    state_d     = S_IDLE;
                    burst_cnt_d = '0;
                    cpu_owed_d  = 1'b1;
                end else begin
                    burst_cnt_d = burst_inc;
                end
            end
            default: begin
                state_d     = S_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            cpu_owed_q   <= 1'b0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_owed_q   <= cpu_owed_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small word-addressed memory model
// behind the mem_* port. DMA read data expected values are queued when a
// granted read is driven and popped when dma_rvalid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_W_en, cpu_R_en;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_RW_type;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [2:0]  dma_RW_type;
    logic        mem_W_en, mem_R_en;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [2:0]  mem_RW_type;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem [0:63] = '{4: 32'hDEADBEEF, 16: 32'h12345678, default: 32'h0};

    dmem_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_W_en(cpu_W_en), .cpu_R_en(cpu_R_en), .cpu_addr(cpu_addr),
        .cpu_RW_type(cpu_RW_type), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_RW_type(dma_RW_type), .dma_wdata(dma_wdata), .dma_lock(dma_lock),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
        .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the clock edge.
    assign mem_dout = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_W_en)
            mem[mem_addr[7:2]] <= mem_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every dma_rvalid pulse must match the oldest queued read.
    always @(negedge clk) begin
        if (dma_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dma_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("dma_rdata_sb", dma_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_W_en = 0; cpu_R_en = 0; cpu_addr = 0; cpu_RW_type = 3'd2; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_RW_type = 3'd2; dma_wdata = 0;
        dma_lock = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset state with both masters requesting.
        cpu_R_en = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h40;
        @(negedge clk);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_mem_R_en", 32'(mem_R_en), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);

        // CPU alone, load from 0x10.
        cyc();
        reset = 1'b0;
        idle_inputs();
        cpu_R_en = 1; cpu_addr = 32'h10;
        @(negedge clk);
        chk("cpu_only_mem_addr", mem_addr, 32'h10);
        chk("cpu_only_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_only_stall", 32'(cpu_stall), 32'd0);
        chk("cpu_only_dma_gnt", 32'(dma_gnt), 32'd0);

        // DMA alone, read from 0x40.
        cyc();
        idle_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 32'h40;
        exp_q.push_back(32'h12345678);
        @(negedge clk);
        chk("dma_rd_gnt", 32'(dma_gnt), 32'd1);
        chk("dma_rd_rvalid_n", 32'(dma_rvalid), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("dma_rd_rvalid_n1", 32'(dma_rvalid), 32'd1);
        chk("dma_rd_data_n1", dma_rdata, 32'h12345678);
        cyc();
        @(negedge clk);
        chk("dma_rd_rvalid_n2", 32'(dma_rvalid), 32'd0);

        // Continuous unlocked conflict: DMA wins every fifth cycle.
        for (int i = 0; i < 12; i++) begin
            cyc();
            cpu_W_en = 1; cpu_addr = 32'h20; cpu_wdata = 32'h0000_0100 + 32'(i);
            dma_req = 1; dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'h0000_0200 + 32'(i);
            @(negedge clk);
            chk($sformatf("conflict_gnt_%0d", i), 32'(dma_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("conflict_stall_%0d", i), 32'(cpu_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        cyc();
        idle_inputs();

        // Locked burst of 12 beats; CPU requests beats 1..8.
        for (int i = 0; i < 12; i++) begin
            cyc();
            idle_inputs();
            dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h40;
            if (i >= 1 && i <= 8) begin
                cpu_R_en = 1; cpu_addr = 32'h10;
            end
            if (i != 8)
                exp_q.push_back(32'h12345678);
            @(negedge clk);
            chk($sformatf("burst_gnt_%0d", i), 32'(dma_gnt), (i != 8) ? 32'd1 : 32'd0);
            chk($sformatf("burst_stall_%0d", i), 32'(cpu_stall),
                (i >= 1 && i <= 7) ? 32'd1 : 32'd0);
            if (i == 8)
                chk("burst_cpu_owed_rdata", cpu_rdata, 32'hDEADBEEF);
        end
        cyc();
        idle_inputs();

        // Reset asserted asynchronously in burst beat 3.
        cyc();
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'h11111111;
        @(negedge clk);
        chk("rb_beat1_gnt", 32'(dma_gnt), 32'd1);
        cyc();
        dma_we = 0; dma_addr = 32'h40;
        exp_q.push_back(32'h12345678);
        @(negedge clk);
        chk("rb_beat2_gnt", 32'(dma_gnt), 32'd1);
        cyc();
        dma_we = 1; dma_addr = 32'h64; dma_wdata = 32'h22222222;
        cpu_W_en = 1; cpu_addr = 32'h68; cpu_wdata = 32'h33333333;
        @(negedge clk);
        chk("rb_beat3_gnt", 32'(dma_gnt), 32'd1);
        chk("rb_beat3_rvalid", 32'(dma_rvalid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rb_async_gnt", 32'(dma_gnt), 32'd0);
        chk("rb_async_mem_W_en", 32'(mem_W_en), 32'd0);
        chk("rb_async_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rb_async_stall", 32'(cpu_stall), 32'd1);
        cyc();
        reset = 1'b0;
        dma_lock = 0;
        @(negedge clk);
        chk("rb_release_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rb_release_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rb_release_mem_W_en", 32'(mem_W_en), 32'd1);
        cyc();
        idle_inputs();

        // DMA write then CPU load of the same word.
        cyc();
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("wr_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("wr_mem_din", mem_din, 32'hA5A5A5A5);
        cyc();
        idle_inputs();
        cpu_R_en = 1; cpu_addr = 32'h80;
        @(negedge clk);
        chk("wr_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);
        chk("wr_cpu_stall", 32'(cpu_stall), 32'd0);
        cyc();
        idle_inputs();
        cyc();
        @(negedge clk);

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
